// File: rtl/sort_stream_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort_stream_controller_pkg
// Description : Shared FSM encoding, group size and pad-key helper for the
//               4-key sort stream controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sort_stream_controller_pkg;

    localparam int GROUP_SIZE = 4;
    localparam int CNT_W      = $clog2(GROUP_SIZE + 1);
    localparam int IDX_W      = $clog2(GROUP_SIZE);
    localparam int PAD_MAX_W  = 64;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Callers truncate to their key width; all-ones sorts after every real key.
    function automatic logic [PAD_MAX_W-1:0] padKey();
        return '1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sort_stream_controller_network.sv
`default_nettype none
// ============================================================================
// Module      : sortingNetwork4
// Description : Combinational 4-input, 5-comparator unsigned sorting network;
//               lane 0 of the output carries the smallest key.
// Revision    : 1.0 - initial release
// ============================================================================
module sortingNetwork4
    import sort_stream_controller_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [GROUP_SIZE*WIDTH-1:0] keysIn,
    output logic [GROUP_SIZE*WIDTH-1:0] keysOut
);

    logic [WIDTH-1:0] w_k0, w_k1, w_k2, w_k3;
    logic [WIDTH-1:0] w_s1Lo01, w_s1Hi01, w_s1Lo23, w_s1Hi23;
    logic [WIDTH-1:0] w_s2Min, w_s2Mid0, w_s2Mid1, w_s2Max;
    logic [WIDTH-1:0] w_s3Lo, w_s3Hi;

    assign w_k0 = keysIn[0*WIDTH +: WIDTH];
    assign w_k1 = keysIn[1*WIDTH +: WIDTH];
    assign w_k2 = keysIn[2*WIDTH +: WIDTH];
    assign w_k3 = keysIn[3*WIDTH +: WIDTH];

    // Stage 1: order each pair.
    assign w_s1Lo01 = (w_k0 < w_k1) ? w_k0 : w_k1;
    assign w_s1Hi01 = (w_k0 < w_k1) ? w_k1 : w_k0;
    assign w_s1Lo23 = (w_k2 < w_k3) ? w_k2 : w_k3;
    assign w_s1Hi23 = (w_k2 < w_k3) ? w_k3 : w_k2;

    // Stage 2: global min and max fall out; the two middle keys remain.
    assign w_s2Min  = (w_s1Lo01 < w_s1Lo23) ? w_s1Lo01 : w_s1Lo23;
    assign w_s2Mid0 = (w_s1Lo01 < w_s1Lo23) ? w_s1Lo23 : w_s1Lo01;
    assign w_s2Mid1 = (w_s1Hi01 < w_s1Hi23) ? w_s1Hi01 : w_s1Hi23;
    assign w_s2Max  = (w_s1Hi01 < w_s1Hi23) ? w_s1Hi23 : w_s1Hi01;

    assign w_s3Lo = (w_s2Mid0 < w_s2Mid1) ? w_s2Mid0 : w_s2Mid1;
    assign w_s3Hi = (w_s2Mid0 < w_s2Mid1) ? w_s2Mid1 : w_s2Mid0;

    assign keysOut = {w_s2Max, w_s3Hi, w_s3Lo, w_s2Min};

endmodule
`default_nettype wire

// File: rtl/sort_stream_controller.sv
`default_nettype none
// ============================================================================
// Module      : sort_stream_controller
// Description : Collects up to four keys, sorts them in one registered pass
//               and streams them out smallest first.
// Revision    : 1.0 - initial release
// ============================================================================
module sort_stream_controller
    import sort_stream_controller_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inData,
    input  logic             inValid,
    input  logic             inLast,
    output logic             inReady,
    output logic [WIDTH-1:0] outData,
    output logic             outValid,
    output logic             outLast,
    input  logic             outReady,
    output logic             busy
);

    state_t                       r_state;
    logic [CNT_W-1:0]             r_cnt;
    logic [IDX_W-1:0]             r_idx;
    logic [WIDTH-1:0]             r_slot [GROUP_SIZE];
    logic [WIDTH-1:0]             r_res  [GROUP_SIZE];

    logic [GROUP_SIZE*WIDTH-1:0]  w_netIn;
    logic [GROUP_SIZE*WIDTH-1:0]  w_netOut;
    logic [WIDTH-1:0]             w_pad;
    logic [IDX_W-1:0]             w_lastIdx;

    assign w_pad     = WIDTH'(padKey());
    assign w_lastIdx = IDX_W'(r_cnt - CNT_W'(1));

    // Unfilled lanes carry the pad key so they sink to the end of the result.
    for (genvar i = 0; i < GROUP_SIZE; i++) begin : g_lane
        assign w_netIn[i*WIDTH +: WIDTH] = (CNT_W'(i) < r_cnt) ? r_slot[i] : w_pad;
    end

    sortingNetwork4 #(
        .WIDTH (WIDTH)
    ) u_network (
        .keysIn  (w_netIn),
        .keysOut (w_netOut)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_idx   <= '0;
            for (int i = 0; i < GROUP_SIZE; i++) begin
                r_slot[i] <= '0;
                r_res[i]  <= '0;
            end
        end else begin
            case (r_state)
                FILL: begin
                    if (inValid) begin
                        r_slot[r_cnt[IDX_W-1:0]] <= inData;
                        r_cnt                    <= r_cnt + CNT_W'(1);
                        if (inLast || (r_cnt == CNT_W'(GROUP_SIZE - 1))) begin
                            r_state <= SORT;
                        end
                    end
                end
                SORT: begin
                    for (int i = 0; i < GROUP_SIZE; i++) begin
                        r_res[i] <= w_netOut[i*WIDTH +: WIDTH];
                    end
                    r_state <= DRAIN;
                end
                DRAIN: begin
                    if (outReady) begin
                        if (r_idx == w_lastIdx) begin
                            r_state <= FILL;
                            r_cnt   <= '0;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    // Handshake outputs decode registered state only.
    assign inReady  = (r_state == FILL);
    assign outValid = (r_state == DRAIN);
    assign outLast  = (r_state == DRAIN) && (r_idx == w_lastIdx);
    assign outData  = r_res[r_idx];
    assign busy     = !((r_state == FILL) && (r_cnt == '0));

endmodule
`default_nettype wire

// File: tb/tb_sort_stream_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_stream_controller
// Description : Self-checking bench: directed and random key groups compared
//               against a queue-sort reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_stream_controller;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] inData;
    logic             inValid;
    logic             inLast;
    logic             inReady;
    logic [WIDTH-1:0] outData;
    logic             outValid;
    logic             outLast;
    logic             outReady;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] keys [$];

    always #5 clk = ~clk;

    sort_stream_controller #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .inData   (inData),
        .inValid  (inValid),
        .inLast   (inLast),
        .inReady  (inReady),
        .outData  (outData),
        .outValid (outValid),
        .outLast  (outLast),
        .outReady (outReady),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives every key in 'keys'; a 3-cycle idle gap (with inLast high but
    // inValid low) is inserted before beat gapAt.
    task automatic sendGroup(input bit useLast, input int gapAt);
        int n = keys.size();
        for (int i = 0; i < n; i++) begin
            if (i == gapAt) begin
                repeat (3) begin
                    @(negedge clk);
                    inValid = 1'b0;
                    inLast  = 1'b1;
                    inData  = WIDTH'($urandom);
                end
            end
            @(negedge clk);
            check("inReady_fill", inReady, 1);
            inValid = 1'b1;
            inData  = keys[i];
            inLast  = useLast && (i == n - 1);
            @(posedge clk);
        end
        #1;
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    // mode 0: outReady always 1; 1: pattern 1,0,0,1; 2: random.
    task automatic drainGroup(input int mode, input bit holdValid);
        logic [WIDTH-1:0] exp [$];
        logic [WIDTH-1:0] prevData;
        bit               pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit               first   = 1'b1;
        bit               stalled = 1'b0;
        logic             rdy;
        int               n   = keys.size();
        int               k   = 0;
        int               cyc = 0;
        int               tog = 0;
        exp = keys;
        exp.sort();
        while (k < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (holdValid) begin
                inValid = 1'b1;
                inData  = WIDTH'($urandom);
                inLast  = 1'($urandom);
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[tog % 4] : 1'($urandom_range(0, 1));
            if (outValid) begin
                tog++;
                if (first) begin
                    check("first_latency", cyc, 2);
                    first = 1'b0;
                end
                check("outData", outData, exp[k]);
                check("outLast", outLast, (k == n - 1));
                check("inReady_drain", inReady, 0);
                if (stalled) check("stall_hold", outData, prevData);
                outReady = rdy;
                if (rdy) begin
                    k++;
                    stalled = 1'b0;
                    if (k == n) inValid = 1'b0;
                end else begin
                    stalled  = 1'b1;
                    prevData = outData;
                end
            end else begin
                if (!first) check("outValid_drop", outValid, 1);
                outReady = rdy;
            end
        end
        if (k < n) check("drain_timeout", k, n);
        @(negedge clk);
        inValid  = 1'b0;
        outReady = 1'b0;
        check("post_outValid", outValid, 0);
        check("post_inReady", inReady, 1);
        check("post_busy", busy, 0);
    endtask

    initial begin
        rst      = 1'b1;
        inData   = '0;
        inValid  = 1'b0;
        inLast   = 1'b0;
        outReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outValid", outValid, 0);
        check("rst_outLast", outLast, 0);
        check("rst_outData", outData, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_inReady", inReady, 1);

        // Full group
        keys = '{16'd7, 16'd3, 16'd9, 16'd1};
        sendGroup(1'b0, -1);
        drainGroup(0, 1'b0);

        // Short group
        keys = '{16'd5, 16'd2};
        sendGroup(1'b1, -1);
        drainGroup(0, 1'b0);

        // Single all-ones key, then duplicates with inLast on the 4th beat
        keys = '{16'hFFFF};
        sendGroup(1'b1, -1);
        drainGroup(0, 1'b0);
        keys = '{16'd4, 16'd4, 16'd4, 16'd4};
        sendGroup(1'b1, -1);
        drainGroup(0, 1'b0);

        // Backpressure with inValid held during drain
        keys = '{16'd8, 16'd6, 16'd2, 16'd0};
        sendGroup(1'b0, -1);
        drainGroup(1, 1'b1);

        // Reset after three accepted keys
        keys = '{16'd9, 16'd9, 16'd9};
        sendGroup(1'b0, -1);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_inReady", inReady, 1);
        keys = '{16'd1, 16'd2, 16'd3, 16'd4};
        sendGroup(1'b0, -1);
        drainGroup(0, 1'b0);

        // Reset during drain
        keys = '{16'd5, 16'd6, 16'd7, 16'd8};
        sendGroup(1'b0, -1);
        begin
            int w = 0;
            @(negedge clk);
            while (!outValid && w < 10) begin
                @(negedge clk);
                w++;
            end
            check("drainrst_reached", outValid, 1);
        end
        rst = 1'b1;
        @(negedge clk);
        check("drainrst_outValid", outValid, 0);
        check("drainrst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("drainrst_inReady", inReady, 1);

        // Input gap between beats 2 and 3
        keys = '{16'd30, 16'd10, 16'd40, 16'd20};
        sendGroup(1'b0, 2);
        drainGroup(0, 1'b0);

        // Random groups
        for (int g = 0; g < 25; g++) begin
            int  n     = $urandom_range(1, 4);
            bit  ties  = 1'($urandom_range(0, 1));
            bit  useL  = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            keys.delete();
            for (int i = 0; i < n; i++) begin
                keys.push_back(ties ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom));
            end
            sendGroup(useL, $urandom_range(0, 4));
            drainGroup(2, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
